// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard/forwarding control.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, FREEZE, FLUSH} hz_state_e;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_e;
  localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: ALU operand forwarding select for one source register; EX/MEM beats MEM/WB.
module fwd_select
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_reg_write_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_reg_write_i,
  output fwd_sel_e   sel_o
);
  assign sel_o = (mem_reg_write_i && mem_rd_i != REG_X0 && mem_rd_i == rs_i) ? FWD_MEM :
                 (wb_reg_write_i && wb_rd_i != REG_X0 && wb_rd_i == rs_i)    ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stalls, taken-branch flushes, dmem freezes, forwarding and stall watchdog.
// Defining HAZARD_PERF_CNT_EN adds perf_stall_cycles / perf_flush_events counters.
module hazard_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic [4:0] mem_rd,
  input  logic [4:0] wb_rd,
  input  logic       mem_reg_write,
  input  logic       wb_reg_write,
  input  logic       mem_branch_taken,
  input  logic       dmem_stall,
  output logic       pc_write_en,
  output logic       if_id_write_en,
  output logic       id_ex_write_en,
  output logic       ex_mem_write_en,
  output logic       mem_wb_write_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_events,
`endif
  output logic       stall_timeout
);
  localparam int CW = $clog2(MAX_STALL + 1);
  hz_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d, load_use;
  fwd_sel_e sel_a, sel_b;
  fwd_select u_fwd_a (.rs_i(ex_rs1), .mem_rd_i(mem_rd), .mem_reg_write_i(mem_reg_write),
                      .wb_rd_i(wb_rd), .wb_reg_write_i(wb_reg_write), .sel_o(sel_a));
  fwd_select u_fwd_b (.rs_i(ex_rs2), .mem_rd_i(mem_rd), .mem_reg_write_i(mem_reg_write),
                      .wb_rd_i(wb_rd), .wb_reg_write_i(wb_reg_write), .sel_o(sel_b));
  assign fwd_a = rst_n ? sel_a : FWD_RF;
  assign fwd_b = rst_n ? sel_b : FWD_RF;
  assign stall_timeout = timeout_q;
  assign load_use = ex_mem_read && ex_rd != REG_X0 &&
                    ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  always_comb begin
    state_d = RUN;
    {pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en} = 5'b11111;
    {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b000;
    if (dmem_stall) begin
      state_d = FREEZE;
      {pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en} = 5'b00000;
    end else if (mem_branch_taken) begin
      state_d = FLUSH;
      {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
    end else if (load_use && state_q != FLUSH) begin
      // ID holds a bubble while in FLUSH, so a load-use match there is spurious
      {pc_write_en, if_id_write_en} = 2'b00;
      id_ex_flush = 1'b1;
    end
    if (!rst_n) begin
      {pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en} = 5'b00000;
      {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
    end
  end
  assign cnt_d = dmem_stall ? (cnt_q == CW'(MAX_STALL) ? cnt_q : cnt_q + 1'b1) : '0;
  assign timeout_d = timeout_q | (cnt_d == CW'(MAX_STALL));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_flush_events <= '0;
    end else begin
      if (!pc_write_en && perf_stall_cycles != 32'hFFFF_FFFF) perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (ex_mem_flush && perf_flush_events != 32'hFFFF_FFFF) perf_flush_events <= perf_flush_events + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed plus random stimulus, reference model feeds a scoreboard queue.
module tb_hazard_unit;
  localparam int MS = 4;
  logic clk = 1'b0, rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, mem_reg_write, wb_reg_write, mem_branch_taken, dmem_stall;
  logic pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, stall_timeout;
  logic [1:0] fwd_a, fwd_b;
  typedef struct packed {
    logic [4:0] we;
    logic [2:0] fl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       to;
  } exp_t;
  exp_t sb[$];
  int compared = 0, mismatched = 0;
  bit in_flush = 0, timeout_m = 0;
  int run_len = 0;
  always #5 clk = ~clk;
  hazard_unit #(.MAX_STALL(MS)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write),
    .wb_reg_write(wb_reg_write), .mem_branch_taken(mem_branch_taken), .dmem_stall(dmem_stall),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .id_ex_write_en(id_ex_write_en),
    .ex_mem_write_en(ex_mem_write_en), .mem_wb_write_en(mem_wb_write_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_timeout(stall_timeout));
  function automatic logic [1:0] fwd_of(input logic [4:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction
  task automatic clr();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rs1, id_uses_rs2, ex_mem_read, mem_reg_write, wb_reg_write, mem_branch_taken, dmem_stall} = '0;
    rst_n = 1'b1;
  endtask
  // inputs are already set just after a negedge; push expectation, then advance the model one edge
  task automatic apply();
    exp_t e;
    bit lu;
    #1;
    lu = ex_mem_read && ex_rd != 0 && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (!rst_n) e = '{we: 5'b00000, fl: 3'b111, fa: 2'b00, fb: 2'b00, to: 1'b0};
    else begin
      e.fa = fwd_of(ex_rs1);
      e.fb = fwd_of(ex_rs2);
      e.to = timeout_m;
      if (dmem_stall) begin e.we = 5'b00000; e.fl = 3'b000; end
      else if (mem_branch_taken) begin e.we = 5'b11111; e.fl = 3'b111; end
      else if (lu && !in_flush) begin e.we = 5'b00111; e.fl = 3'b010; end
      else begin e.we = 5'b11111; e.fl = 3'b000; end
    end
    sb.push_back(e);
    @(posedge clk);
    if (!rst_n) begin in_flush = 0; run_len = 0; timeout_m = 0; end
    else begin
      in_flush = !dmem_stall && mem_branch_taken;
      run_len = dmem_stall ? ((run_len + 1 > MS) ? MS : run_len + 1) : 0;
      if (run_len == MS) timeout_m = 1;
    end
    @(negedge clk);
  endtask
  task automatic chk(input string n, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, req);
    end
  endtask
  initial forever begin
    @(negedge clk);
    #3;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("write_en", {pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en}, e.we);
      chk("flush", {if_id_flush, id_ex_flush, ex_mem_flush}, e.fl);
      chk("fwd_a", fwd_a, e.fa);
      chk("fwd_b", fwd_b, e.fb);
      chk("stall_timeout", stall_timeout, e.to);
    end
  end
  initial begin
    clr();
    rst_n = 1'b0;
    @(negedge clk);
    apply(); apply();
    rst_n = 1'b1;
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_rs2 = 7; id_uses_rs1 = 1; id_uses_rs2 = 1;
    apply();
    clr(); ex_rs1 = 5; ex_rs2 = 7; wb_rd = 5; wb_reg_write = 1;
    apply();
    clr(); ex_mem_read = 1; id_uses_rs1 = 1;
    apply();
    clr(); mem_branch_taken = 1;
    apply();
    clr(); ex_mem_read = 1; ex_rd = 3; id_rs2 = 3; id_uses_rs2 = 1;
    apply();
    apply();
    clr(); mem_branch_taken = 1; dmem_stall = 1;
    repeat (3) apply();
    dmem_stall = 0;
    apply();
    clr(); ex_rs2 = 9; mem_rd = 9; wb_rd = 9; mem_reg_write = 1; wb_reg_write = 1;
    apply();
    mem_reg_write = 0;
    apply();
    clr(); dmem_stall = 1;
    repeat (6) apply();
    dmem_stall = 0;
    repeat (3) apply();
    rst_n = 0;
    apply();
    rst_n = 1;
    apply();
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(0, 199) != 0;
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom); ex_mem_read = 1'($urandom);
      mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
      mem_branch_taken = $urandom_range(0, 4) == 0;
      dmem_stall = (i % 400 < 40) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 2);
      apply();
    end
    @(negedge clk);
    #5;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
